// File: rtl/uart_rx_cmd_parser.sv
// Assembles SYNC/ADDR/DATA[/CHK] byte frames from the UART RX path into register-write commands.
// Optional feature: define UART_RX_CMD_CHECKSUM_EN to add the trailing checksum byte and Chk_err.
module uart_rx_cmd_parser #(
    parameter int         WORD_SIZE      = 8,
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TIMEOUT_WIDTH  = 17
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [WORD_SIZE-1:0]    RX_Byte_in,
    input  logic                    RX_Byte_valid,
    input  logic                    Cmd_ready,
    output logic                    Cmd_valid,
    output logic [7:0]              Cmd_addr,
    output logic [8*DATA_BYTES-1:0] Cmd_data,
    output logic                    Chk_err,
    output logic                    Timeout_err,
    output logic                    Overrun_err
);

    localparam int DW = 8 * DATA_BYTES;

`ifdef UART_RX_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD} state_t;
`endif

    state_t                   state_q;
    logic [2:0]               byteCnt_q;
    logic [TIMEOUT_WIDTH-1:0] tmoCnt_q;
    logic [7:0]               addr_q;
    logic [DW-1:0]            data_q;
    logic                     cmdValid_q;
    logic                     tmoErr_q;
    logic                     overrun_q;
    logic [DW-1:0]            data_d;
    logic                     lastData;
    logic                     tmoHit;
    logic                     inFrame;

`ifdef UART_RX_CMD_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic       chkErr_q;
`endif

    always_comb begin
        data_d   = (data_q << WORD_SIZE) | DW'(RX_Byte_in);
        lastData = (byteCnt_q == 3'(DATA_BYTES - 1));
        tmoHit   = (tmoCnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
        inFrame  = (state_q == ADDR) || (state_q == DATA);
`ifdef UART_RX_CMD_CHECKSUM_EN
        sum_d    = sum_q + RX_Byte_in;
        inFrame  = inFrame || (state_q == CHK);
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            byteCnt_q  <= '0;
            tmoCnt_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cmdValid_q <= 1'b0;
            tmoErr_q   <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_CMD_CHECKSUM_EN
            sum_q      <= '0;
            chkErr_q   <= 1'b0;
`endif
        end else begin
            tmoErr_q <= 1'b0;
`ifdef UART_RX_CMD_CHECKSUM_EN
            chkErr_q <= 1'b0;
`endif
            // A byte in the limit cycle wins over the timeout.
            if (inFrame) begin
                if (RX_Byte_valid) begin
                    tmoCnt_q <= '0;
                end else if (tmoHit) begin
                    tmoCnt_q <= '0;
                    tmoErr_q <= 1'b1;
                    state_q  <= IDLE;
                end else begin
                    tmoCnt_q <= tmoCnt_q + TIMEOUT_WIDTH'(1);
                end
            end else begin
                tmoCnt_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (RX_Byte_valid && (RX_Byte_in == SYNC_BYTE)) begin
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (RX_Byte_valid) begin
                        addr_q    <= RX_Byte_in;
                        byteCnt_q <= '0;
                        state_q   <= DATA;
`ifdef UART_RX_CMD_CHECKSUM_EN
                        sum_q     <= RX_Byte_in;
`endif
                    end
                end
                DATA: begin
                    if (RX_Byte_valid) begin
                        data_q    <= data_d;
                        byteCnt_q <= byteCnt_q + 3'd1;
`ifdef UART_RX_CMD_CHECKSUM_EN
                        sum_q     <= sum_d;
                        if (lastData) begin
                            state_q <= CHK;
                        end
`else
                        if (lastData) begin
                            state_q    <= HOLD;
                            cmdValid_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef UART_RX_CMD_CHECKSUM_EN
                CHK: begin
                    if (RX_Byte_valid) begin
                        if (RX_Byte_in == sum_q) begin
                            state_q    <= HOLD;
                            cmdValid_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            chkErr_q <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (RX_Byte_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (Cmd_ready) begin
                        state_q    <= IDLE;
                        cmdValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Cmd_valid   = cmdValid_q;
    assign Cmd_addr    = addr_q;
    assign Cmd_data    = data_q;
    assign Timeout_err = tmoErr_q;
    assign Overrun_err = overrun_q;
`ifdef UART_RX_CMD_CHECKSUM_EN
    assign Chk_err     = chkErr_q;
`else
    assign Chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Randomised and directed bench for uart_rx_cmd_parser against a frame-level reference model.
// Follows UART_RX_CMD_CHECKSUM_EN the same way as the design.
module tb_uart_rx_cmd_parser;

    localparam int DB  = 2;
    localparam int TMO = 50;
`ifdef UART_RX_CMD_CHECKSUM_EN
    localparam int FRAME_LEN = DB + 2;
`else
    localparam int FRAME_LEN = DB + 1;
`endif

    logic            clk = 1'b0;
    logic            reset_b = 1'b0;
    logic [7:0]      rxByte = '0;
    logic            rxValid = 1'b0;
    logic            cmdReady = 1'b0;
    logic            cmdValid;
    logic [7:0]      cmdAddr;
    logic [8*DB-1:0] cmdData;
    logic            chkErr;
    logic            tmoErr;
    logic            ovrErr;

    int total = 0;
    int bad = 0;

    // Reference model state: frame bytes collected after SYNC, plus expected outputs.
    logic       mdlBusy, mdlHold;
    int         mdlGap;
    logic [7:0] mdlFrame[$];
    logic       expValid, expChk, expTmo, expOvr;
    logic [7:0] expAddr;
    logic [31:0] expData;
    logic [7:0] txq[$];

    uart_rx_cmd_parser #(
        .WORD_SIZE(8), .DATA_BYTES(DB), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(17)
    ) dut (
        .clk(clk), .reset_b(reset_b),
        .RX_Byte_in(rxByte), .RX_Byte_valid(rxValid), .Cmd_ready(cmdReady),
        .Cmd_valid(cmdValid), .Cmd_addr(cmdAddr), .Cmd_data(cmdData),
        .Chk_err(chkErr), .Timeout_err(tmoErr), .Overrun_err(ovrErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mdlBusy = 0; mdlHold = 0; mdlGap = 0; mdlFrame.delete();
        expValid = 0; expChk = 0; expTmo = 0; expOvr = 0; expAddr = 0; expData = 0;
    endtask

    task automatic modelFinishFrame();
        int   sum;
        logic ok;
        sum = 0;
        for (int i = 0; i <= DB; i++) sum += int'(mdlFrame[i]);
        sum = sum % 256;
`ifdef UART_RX_CMD_CHECKSUM_EN
        ok = (int'(mdlFrame[DB+1]) == sum);
`else
        ok = 1'b1;
`endif
        if (ok) begin
            mdlHold  = 1;
            expValid = 1;
            expAddr  = mdlFrame[0];
            expData  = 0;
            for (int i = 1; i <= DB; i++) expData = (expData << 8) | 32'(mdlFrame[i]);
        end else begin
            expChk = 1;
        end
        mdlBusy = 0;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] b, input logic r);
        expChk = 0;
        expTmo = 0;
        if (mdlHold) begin
            if (v) expOvr = 1;
            if (r) begin
                mdlHold  = 0;
                expValid = 0;
            end
        end else if (!mdlBusy) begin
            if (v && b == 8'hA5) begin
                mdlBusy = 1;
                mdlGap  = 0;
                mdlFrame.delete();
            end
        end else if (v) begin
            mdlFrame.push_back(b);
            mdlGap = 0;
            if (mdlFrame.size() == FRAME_LEN) modelFinishFrame();
        end else begin
            mdlGap++;
            if (mdlGap == TMO) begin
                expTmo  = 1;
                mdlBusy = 0;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("Cmd_valid", 32'(cmdValid), 32'(expValid));
        checkOutput("Chk_err", 32'(chkErr), 32'(expChk));
        checkOutput("Timeout_err", 32'(tmoErr), 32'(expTmo));
        checkOutput("Overrun_err", 32'(ovrErr), 32'(expOvr));
        if (expValid) begin
            checkOutput("Cmd_addr", 32'(cmdAddr), 32'(expAddr));
            checkOutput("Cmd_data", 32'(cmdData), expData);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare away from it.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r);
        rxValid  = v;
        rxByte   = v ? b : $urandom_range(0, 255);
        cmdReady = r;
        @(posedge clk);
        #1;
        modelStep(v, b, r);
        checkAll();
        rxValid = 0;
    endtask

    task automatic idleCycles(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, r);
    endtask

    task automatic sendQueue(input logic r);
        while (txq.size() > 0) applyStimulus(1, txq.pop_front(), r);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(cmdValid), 0);
        checkOutput({tag, "_addr"}, 32'(cmdAddr), 0);
        checkOutput({tag, "_data"}, 32'(cmdData), 0);
        checkOutput({tag, "_errs"}, {29'd0, chkErr, tmoErr, ovrErr}, 0);
    endtask

    task automatic pushGoodFrame(input logic [7:0] a, input logic [15:0] d);
        txq.push_back(8'hA5); txq.push_back(a);
        txq.push_back(d[15:8]); txq.push_back(d[7:0]);
`ifdef UART_RX_CMD_CHECKSUM_EN
        txq.push_back(a + d[15:8] + d[7:0]);
`endif
    endtask

    initial begin
        logic [7:0] a, c;
        logic [15:0] d;
        int gap;
        modelReset();
        #23;
        checkResetOutputs("reset");
        @(negedge clk);
        reset_b = 1;
        @(posedge clk);
        #1;

        // Basic frame with ready held high, then checksum error and wrap-around sum.
        txq = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h56};
        sendQueue(1);
        idleCycles(3, 1);
        txq = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h57};
        sendQueue(1);
        idleCycles(3, 1);
        txq = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        sendQueue(1);
        idleCycles(3, 1);

        // Timeout after exactly TMO silent cycles, then a byte landing on the limit cycle.
        txq = '{8'hA5, 8'h10};
        sendQueue(1);
        idleCycles(TMO + 2, 1);
        txq = '{8'hA5, 8'h10};
        sendQueue(1);
        idleCycles(TMO - 1, 1);
        txq = '{8'h12, 8'h34, 8'h56};
        sendQueue(1);
        idleCycles(3, 1);

        // Leading garbage and SYNC values used as payload.
        txq = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'hA5, 8'hA5, 8'h6A};
        sendQueue(1);
        idleCycles(3, 1);

        // Command held with ready low, extra byte during HOLD, then accept.
        pushGoodFrame(8'h42, 16'hBEEF);
        sendQueue(0);
        idleCycles(8, 0);
        applyStimulus(1, 8'h33, 0);
        idleCycles(11, 0);
        applyStimulus(0, 8'h00, 1);
        idleCycles(2, 1);

        // Asynchronous reset in the middle of DATA.
        txq = '{8'hA5, 8'h10, 8'h12};
        sendQueue(1);
        #3;
        reset_b = 0;
        #1;
        modelReset();
        checkResetOutputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("inreset");
        @(negedge clk);
        reset_b = 1;
        @(posedge clk);
        #1;
        txq = '{8'h34, 8'h56};
        sendQueue(1);
        pushGoodFrame(8'h07, 16'h0102);
        sendQueue(1);
        idleCycles(3, 1);

        // Randomised frames: garbage, corrupted checksums, gaps around the limit, random ready.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) txq.push_back($urandom_range(0, 255));
            a = $urandom_range(0, 255);
            d = $urandom_range(0, 65535);
            c = a + d[15:8] + d[7:0];
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            txq.push_back(8'hA5); txq.push_back(a);
            txq.push_back(d[15:8]); txq.push_back(d[7:0]);
`ifdef UART_RX_CMD_CHECKSUM_EN
            txq.push_back(c);
`endif
            while (txq.size() > 0) begin
                case ($urandom_range(0, 9))
                    0: gap = TMO - 1;
                    1: gap = TMO;
                    default: gap = $urandom_range(0, 2);
                endcase
                for (int i = 0; i < gap; i++) applyStimulus(0, 8'h00, $urandom_range(0, 3) != 0);
                applyStimulus(1, txq.pop_front(), $urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
